// File: rtl/compare_result_debouncer_pkg.sv
// Shared definitions for the comparator result path: relation state
// encoding and sizing helpers used by the debouncer and its consumers.
package compare_result_debouncer_pkg;

    // Width of the encoded relation state carried between blocks.
    localparam int STATE_WIDTH = 2;

    typedef logic [STATE_WIDTH-1:0] state_t;

    localparam state_t STATE_UNKNOWN = 2'd0;
    localparam state_t STATE_LESS    = 2'd1;
    localparam state_t STATE_EQUAL   = 2'd2;
    localparam state_t STATE_GREATER = 2'd3;

    // Bits needed for a counter that must reach the value n inclusive.
    function automatic int run_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/compare_result_debouncer_flag_decode.sv
// compare_flag_decode: maps raw one-hot comparator flags to a relation state.
// Ports: a_lt_b/a_gt_b/a_eq_b flags in; state (2b) and malformed out.
module compare_flag_decode
    import compare_result_debouncer_pkg::*;
(
    input  logic   a_lt_b,
    input  logic   a_gt_b,
    input  logic   a_eq_b,
    output state_t state,
    output logic   malformed
);

    // Anything other than exactly one flag is reported as malformed and
    // decodes to UNKNOWN so it can never match a real candidate.
    always_comb begin
        state     = STATE_UNKNOWN;
        malformed = 1'b0;
        unique case ({a_lt_b, a_gt_b, a_eq_b})
            3'b100:  state = STATE_LESS;
            3'b010:  state = STATE_GREATER;
            3'b001:  state = STATE_EQUAL;
            default: malformed = 1'b1;
        endcase
    end

endmodule

// File: rtl/compare_result_debouncer.sv
// compare_result_debouncer: filters comparator flags into a debounced
// relation state, emits one-entry ready/valid change events, counts changes.
// Ports: clock, reset (sync, active high); in_valid + a_lt_b/a_gt_b/a_eq_b
// sample in; state_out; event_valid/event_ready/event_state handshake;
// change_count; flag_error pulse; event_overrun sticky flag.
module compare_result_debouncer
    import compare_result_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   a_lt_b,
    input  logic                   a_gt_b,
    input  logic                   a_eq_b,
    output logic [STATE_WIDTH-1:0] state_out,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [STATE_WIDTH-1:0] event_state,
    output logic [COUNT_WIDTH-1:0] change_count,
    output logic                   flag_error,
    output logic                   event_overrun
);

    localparam int RUN_WIDTH = run_width(DEBOUNCE_CYCLES);

    localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [RUN_WIDTH-1:0] RUN_ONE = RUN_WIDTH'(1);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    state_t                 decoded;
    logic                   malformed;

    state_t                 candidate;
    state_t                 candidate_next;
    logic [RUN_WIDTH-1:0]   run_count;
    logic [RUN_WIDTH-1:0]   run_next;
    logic                   adopt;
    logic                   transfer;

    compare_flag_decode u_decode (
        .a_lt_b    (a_lt_b),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .state     (decoded),
        .malformed (malformed)
    );

    // Run tracking. Idle cycles leave the run untouched so gaps between
    // samples do not break it; a malformed sample restarts from nothing.
    always_comb begin
        candidate_next = candidate;
        run_next       = run_count;
        if (in_valid) begin
            if (malformed) begin
                candidate_next = STATE_UNKNOWN;
                run_next       = '0;
            end else if (decoded == candidate) begin
                run_next = (run_count == RUN_MAX) ? RUN_MAX
                                                  : run_count + RUN_ONE;
            end else begin
                candidate_next = decoded;
                run_next       = RUN_ONE;
            end
        end
    end

    // Adopt only on the exact edge the run reaches its target; a saturated
    // run stays at RUN_MAX without re-triggering.
    always_comb begin
        adopt = in_valid && !malformed
             && (run_next == RUN_MAX)
             && (decoded != state_t'(state_out));
    end

    assign transfer = event_valid && event_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            candidate     <= STATE_UNKNOWN;
            run_count     <= '0;
            state_out     <= STATE_UNKNOWN;
            event_valid   <= 1'b0;
            event_state   <= STATE_UNKNOWN;
            change_count  <= '0;
            flag_error    <= 1'b0;
            event_overrun <= 1'b0;
        end else begin
            candidate  <= candidate_next;
            run_count  <= run_next;
            flag_error <= in_valid && malformed;
            if (adopt) begin
                state_out    <= decoded;
                change_count <= change_count + COUNT_ONE;
                // A held event that is not leaving this edge gets replaced.
                if (event_valid && !event_ready) begin
                    event_overrun <= 1'b1;
                end
                event_valid <= 1'b1;
                event_state <= decoded;
            end else if (transfer) begin
                event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_compare_result_debouncer.sv
// Randomised scoreboard bench for compare_result_debouncer.
// Reference model works on the history of decoded samples.
module tb_compare_result_debouncer;

    localparam int DC = 4;
    localparam int CW = 8;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          a_lt_b;
    logic          a_gt_b;
    logic          a_eq_b;
    logic [1:0]    state_out;
    logic          event_valid;
    logic          event_ready;
    logic [1:0]    event_state;
    logic [CW-1:0] change_count;
    logic          flag_error;
    logic          event_overrun;

    compare_result_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .a_lt_b        (a_lt_b),
        .a_gt_b        (a_gt_b),
        .a_eq_b        (a_eq_b),
        .state_out     (state_out),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_state   (event_state),
        .change_count  (change_count),
        .flag_error    (flag_error),
        .event_overrun (event_overrun)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    typedef struct {
        int st;
        int ev_valid;
        int ev_state;
        int count;
        int ferr;
        int ovr;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_hist[$];
    int m_state = 0;
    int m_ev_valid = 0;
    int m_ev_state = 0;
    int m_count = 0;
    int m_ferr = 0;
    int m_ovr = 0;

    function automatic void chk(input string name, input int act,
                                input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Expected outputs after the coming edge, from the current inputs.
    function automatic void model_step();
        exp_t e;
        int   ones;
        int   v;
        int   streak;
        int   load;
        int   xfer;
        if (reset) begin
            m_hist.delete();
            m_state    = 0;
            m_ev_valid = 0;
            m_ev_state = 0;
            m_count    = 0;
            m_ferr     = 0;
            m_ovr      = 0;
        end else begin
            m_ferr = 0;
            load   = 0;
            v      = 0;
            xfer   = (m_ev_valid != 0) && event_ready;
            if (in_valid) begin
                ones = int'(a_lt_b) + int'(a_gt_b) + int'(a_eq_b);
                if (ones != 1) begin
                    m_ferr = 1;
                    m_hist.push_back(-1);
                end else begin
                    v = a_lt_b ? 1 : (a_eq_b ? 2 : 3);
                    m_hist.push_back(v);
                    streak = 0;
                    for (int i = m_hist.size() - 1; i >= 0; i--) begin
                        if (m_hist[i] == v) streak++;
                        else break;
                    end
                    load = (streak == DC) && (v != m_state);
                end
                while (m_hist.size() > DC + 1) void'(m_hist.pop_front());
            end
            if (load != 0) begin
                m_state = v;
                m_count = (m_count + 1) % (1 << CW);
                if (m_ev_valid != 0 && xfer == 0) m_ovr = 1;
                m_ev_valid = 1;
                m_ev_state = v;
            end else if (xfer != 0) begin
                m_ev_valid = 0;
            end
        end
        e.st       = m_state;
        e.ev_valid = m_ev_valid;
        e.ev_state = m_ev_state;
        e.count    = m_count;
        e.ferr     = m_ferr;
        e.ovr      = m_ovr;
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic rst, input logic v,
                         input logic [2:0] f, input logic rdy);
        @(negedge clock);
        reset       = rst;
        in_valid    = v;
        a_lt_b      = f[2];
        a_gt_b      = f[1];
        a_eq_b      = f[0];
        event_ready = rdy;
        model_step();
    endtask

    function automatic logic [2:0] flags_of(input int code);
        logic [2:0] f;
        case (code)
            1:       f = 3'b100;
            2:       f = 3'b001;
            3:       f = 3'b010;
            default: f = 3'b110;
        endcase
        return f;
    endfunction

    task automatic sample(input int code, input logic rdy);
        drive(1'b0, 1'b1, flags_of(code), rdy);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 3'($urandom), rdy);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'($urandom), 3'($urandom), 1'($urandom));
    endtask

    task automatic random_malformed(input logic rdy);
        logic [2:0] bad [5];
        bad[0] = 3'b000;
        bad[1] = 3'b011;
        bad[2] = 3'b101;
        bad[3] = 3'b110;
        bad[4] = 3'b111;
        drive(1'b0, 1'b1, bad[$urandom_range(0, 4)], rdy);
    endtask

    // Monitor: compares every output once per edge against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state_out",     int'(state_out),     e.st);
                chk("event_valid",   int'(event_valid),   e.ev_valid);
                chk("event_state",   int'(event_state),   e.ev_state);
                chk("change_count",  int'(change_count),  e.count);
                chk("flag_error",    int'(flag_error),    e.ferr);
                chk("event_overrun", int'(event_overrun), e.ovr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int code;
        int len;
        reset       = 1'b1;
        in_valid    = 1'b0;
        a_lt_b      = 1'b0;
        a_gt_b      = 1'b0;
        a_eq_b      = 1'b0;
        event_ready = 1'b0;

        do_reset(2);
        idle(1'b0);

        // Four GREATER samples with gaps, then a fifth one
        sample(3, 1'b0); idle(1'b0);
        sample(3, 1'b0); idle(1'b0); idle(1'b0);
        sample(3, 1'b0); idle(1'b0);
        sample(3, 1'b0);
        sample(3, 1'b0);

        // Broken LESS runs, then a full one
        repeat (3) sample(1, 1'b0);
        sample(2, 1'b0);
        repeat (3) sample(1, 1'b0);
        sample(1, 1'b0);
        idle(1'b1);

        // Malformed sample inside an EQUAL run
        repeat (2) sample(2, 1'b0);
        drive(1'b0, 1'b1, 3'b110, 1'b0);
        idle(1'b0);
        repeat (3) sample(2, 1'b0);
        sample(2, 1'b0);

        // Overrun, then load on a transferring edge
        do_reset(1);
        repeat (4) sample(3, 1'b0);
        repeat (4) sample(1, 1'b0);
        repeat (3) sample(2, 1'b0);
        sample(2, 1'b1);
        idle(1'b0);

        // Reset in the middle of a run
        do_reset(1);
        repeat (3) sample(3, 1'b0);
        do_reset(1);
        sample(3, 1'b0);
        idle(1'b0);
        repeat (3) sample(3, 1'b1);
        idle(1'b1);

        // Randomised bursts
        for (int b = 0; b < 400; b++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
            code = $urandom_range(1, 3);
            len  = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1'($urandom));
                if ($urandom_range(0, 24) == 0)
                    random_malformed(1'($urandom));
                else
                    sample(code, 1'($urandom));
            end
        end

        repeat (2) @(posedge clock);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/compare_result_debouncer.md
Name: compare_result_debouncer

Overview:
Sequential stage directly downstream of the 8-bit comparator. It consumes the per-sample a_lt_b / a_gt_b / a_eq_b flags and filters them into a debounced relation state. It emits a one-entry, ready/valid change event and counts accepted state changes. It turns a noisy combinational compare into a stable, registered decision for control logic and displays.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive matching valid samples required to adopt a new state; legal range 1..15.
COUNT_WIDTH, 8, width of change_count.

Ports:
clock  input  1  system clock, all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  the comparator flags carry a sample this cycle.
a_lt_b  input  1  comparator less-than flag.
a_gt_b  input  1  comparator greater-than flag.
a_eq_b  input  1  comparator equal flag.
state_out  output  2  debounced relation: 0 UNKNOWN, 1 LESS, 2 EQUAL, 3 GREATER.
event_valid  output  1  a change event is held for the consumer.
event_ready  input  1  the consumer accepts the held event this cycle.
event_state  output  2  new state carried by the held event.
change_count  output  COUNT_WIDTH  number of state changes adopted since reset; wraps.
flag_error  output  1  one-cycle pulse: a valid sample had not exactly one flag set.
event_overrun  output  1  sticky: an unaccepted event was overwritten.

Behaviour:
- Reset (sampled on the edge): state_out=0, event_valid=0, event_state=0, change_count=0, flag_error=0, event_overrun=0. Internal candidate is UNKNOWN and run counter is 0. Reset takes priority over all other activity and aborts any run in progress.
- Decode (combinational): exactly one flag high maps to LESS, EQUAL or GREATER. Any other combination is malformed.
- in_valid=0: no internal or output changes, except flag_error returns to 0. Gaps do not break a run.
- Valid, malformed sample: flag_error=1 for the next cycle only. Run counter is cleared to 0, candidate is set to UNKNOWN, and state_out is held.
- Valid, well-formed sample equal to the candidate: run counter increments, saturating at DEBOUNCE_CYCLES.
- Valid, well-formed sample different from the candidate: candidate takes the decoded value and run counter is set to 1.
- Adoption condition: the new run count equals DEBOUNCE_CYCLES and the decoded value differs from state_out. When it holds, on the same edge:
  - state_out takes the decoded value;
  - change_count increments (modulo 2^COUNT_WIDTH);
  - an event is loaded into the holding register.
- Latency: state_out changes on the edge that samples the DEBOUNCE_CYCLES-th consecutive matching valid sample. With DEBOUNCE_CYCLES=1 this is the edge that samples the first sample.
- Run counter width is the minimum needed to hold DEBOUNCE_CYCLES.
- Once the run is saturated, further matching samples cause no new events. A run that returns to the current state_out value causes no event.
- Event handshake: transfer occurs when event_valid and event_ready are both 1 at an edge. event_valid and event_state stay stable until transfer.
- Event transfer with no new load: event_valid drops to 0.
- New load with no event held: event_valid becomes 1 carrying the new state.
- New load while an event is held and transferring on the same edge: event_valid stays 1 carrying the new state. No overrun.
- New load while an event is held and not transferring: event_state is overwritten with the newest state and event_overrun is set. event_overrun is cleared only by reset.
- event_ready while event_valid=0: no effect.

Decomposition:
- Shared header/package holds:
  - state encoding constants (STATE_UNKNOWN=0, STATE_LESS=1, STATE_EQUAL=2, STATE_GREATER=3);
  - the 2-bit state width constant.
  Later blocks consuming state_out use the same header.
- One sub-module is natural: compare_flag_decode. It is purely combinational and maps the three flags to a 2-bit state plus a malformed bit. It is reusable wherever raw comparator flags are consumed.
- The run counter, state register, event holding register and counter stay in the top module.

Test Plan:
- Reset asserted 2 cycles with random flags -> all outputs 0 on the cycle after reset; state_out=0.
- DEBOUNCE_CYCLES=4, event_ready=0: 4 valid GREATER samples (idle gaps inserted between them) -> after the 4th sampling edge: state_out=3, event_valid=1, event_state=3, change_count=1. A 5th GREATER sample -> no change.
- Starting from GREATER: 3 LESS, 1 EQUAL, 3 LESS samples -> state_out stays 3 throughout. A 4th consecutive LESS sample -> state_out=1, change_count=2.
- Valid sample with a_lt_b=1 and a_gt_b=1 after 2 EQUAL samples -> flag_error=1 for exactly one cycle and state_out is unchanged. 4 further EQUAL samples are needed before state_out=2.
- Event_ready held 0 across two adoptions (GREATER then LESS) -> event_state=1 and event_overrun=1. Then event_ready=1 on the same edge as a third adoption (EQUAL) -> event_valid stays 1, event_state=2, and event_overrun remains 1.
- Reset asserted after 3 of 4 matching samples -> all outputs clear. The next single matching sample does not adopt; a full 4 are required.
